// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg -- shared types for the multi-cycle ALU.
//   alu_op_e : 4-bit opcode encoding carried on ALUopsel
//   state_e  : handshake/iteration FSM states
//   is_shift : true for the opcodes that iterate one bit per cycle
// Optional feature macro used by the design: ALU_MC_MUL_EN (iterative multiplier).
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_PASS_A = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_PASS_B = 4'b0100,
        OP_MUL    = 4'b0101,
        OP_PASS_C = 4'b0110,
        OP_AND    = 4'b1000,
        OP_OR     = 4'b1001,
        OP_XOR    = 4'b1010,
        OP_NOT    = 4'b1011,
        OP_SHR    = 4'b1100,
        OP_SHL    = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_mc_core.sv
// alu_mc_core -- combinational single-cycle ALU operations.
//   a, b  : operands
//   op    : opcode (alu_op_e encoding)
//   res   : result; shifts return a unchanged (the shift-by-zero case),
//           MUL and undefined codes return 0
//   c, o  : carry/borrow and signed overflow for ADD/SUB, 0 otherwise
module alu_mc_core
    import alu_mc_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [3:0]        op,
    output logic [DWIDTH-1:0] res,
    output logic              c,
    output logic              o
);

    logic [DWIDTH:0] sum_s;
    logic [DWIDTH:0] diff_s;

    // Extended-width add/subtract: the extra MSB is carry-out, or borrow (a < b unsigned).
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Opcode decode for the single-cycle datapath.
    always_comb begin
        res = '0;
        c   = 1'b0;
        o   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum_s[DWIDTH-1:0];
                c   = sum_s[DWIDTH];
                o   = (a[DWIDTH-1] == b[DWIDTH-1]) && (sum_s[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_SUB: begin
                res = diff_s[DWIDTH-1:0];
                c   = diff_s[DWIDTH];
                o   = (a[DWIDTH-1] != b[DWIDTH-1]) && (diff_s[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_AND:    res = a & b;
            OP_OR:     res = a | b;
            OP_XOR:    res = a ^ b;
            OP_NOT:    res = ~a;
            OP_PASS_A: res = a;
            OP_PASS_B: res = a;
            OP_PASS_C: res = a;
            OP_SHL:    res = a;
            OP_SHR:    res = a;
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready handshake on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operation offer / accept (accept only in IDLE)
//   op1, op2, ALUopsel    : operands and opcode, captured on acceptance
//   out_valid/out_ready   : result offer / consume (held in DONE)
//   result, c/z/o/s_flag  : registered result and flags
// Shifts by k>0 take k+1 cycles, MUL takes DWIDTH+1 cycles, all else 1.
// Macro ALU_MC_MUL_EN includes the shift-and-add multiplier; without it
// opcode 0101 behaves as an undefined opcode.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int SHW    = $clog2(DWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [3:0]        ALUopsel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag
);

    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};
`ifdef ALU_MC_MUL_EN
    localparam logic [SHW:0] CNT_MUL = DWIDTH[SHW:0];
`endif

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DWIDTH-1:0] opa_q, opa_d;      // shift register / multiplicand
    logic [SHW:0]      cnt_q, cnt_d;      // remaining iterations
    logic [DWIDTH-1:0] result_q, result_d;
    logic              c_q, c_d, z_q, z_d, o_q, o_d, s_q, s_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
`ifdef ALU_MC_MUL_EN
    logic [DWIDTH-1:0] acc_q, acc_d;      // partial product
    logic [DWIDTH-1:0] opb_q, opb_d;      // multiplier, consumed LSB first
`endif

    logic [SHW-1:0]    shamt_s;
    logic [DWIDTH-1:0] core_res_s;
    logic              core_c_s, core_o_s;
    logic [DWIDTH-1:0] iter_val_s;
    logic              iter_c_s;

    assign shamt_s = op2[SHW-1:0];

    alu_mc_core #(.DWIDTH(DWIDTH)) u_core (
        .a   (op1),
        .b   (op2),
        .op  (ALUopsel),
        .res (core_res_s),
        .c   (core_c_s),
        .o   (core_o_s)
    );

    // Next-state, iteration datapath and result/flag capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        c_d        = c_q;
        z_d        = z_q;
        o_d        = o_q;
        s_d        = s_q;
`ifdef ALU_MC_MUL_EN
        acc_d      = acc_q;
        opb_d      = opb_q;
`endif
        iter_val_s = '0;
        iter_c_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = ALUopsel;
                    opa_d = op1;
                    if (is_shift(ALUopsel) && (shamt_s != '0)) begin
                        cnt_d   = {1'b0, shamt_s};
                        state_d = BUSY;
                    end
`ifdef ALU_MC_MUL_EN
                    else if (ALUopsel == OP_MUL) begin
                        opb_d   = op2;
                        acc_d   = '0;
                        cnt_d   = CNT_MUL;
                        state_d = BUSY;
                    end
`endif
                    else begin
                        // Single-cycle ops, including shift by zero.
                        result_d = core_res_s;
                        c_d      = core_c_s;
                        o_d      = core_o_s;
                        z_d      = (core_res_s == '0);
                        s_d      = core_res_s[DWIDTH-1];
                        state_d  = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                case (op_q)
                    OP_SHL: begin
                        iter_c_s   = opa_q[DWIDTH-1];
                        iter_val_s = {opa_q[DWIDTH-2:0], 1'b0};
                        opa_d      = iter_val_s;
                    end
                    OP_SHR: begin
                        iter_c_s   = opa_q[0];
                        iter_val_s = {1'b0, opa_q[DWIDTH-1:1]};
                        opa_d      = iter_val_s;
                    end
`ifdef ALU_MC_MUL_EN
                    OP_MUL: begin
                        iter_val_s = acc_q + (opb_q[0] ? opa_q : '0);
                        acc_d      = iter_val_s;
                        opa_d      = {opa_q[DWIDTH-2:0], 1'b0};
                        opb_d      = {1'b0, opb_q[DWIDTH-1:1]};
                    end
`endif
                    default: begin
                        iter_val_s = '0;
                        iter_c_s   = 1'b0;
                    end
                endcase
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Last iteration: the carry is the final bit shifted out.
                    result_d = iter_val_s;
                    c_d      = iter_c_s;
                    o_d      = 1'b0;
                    z_d      = (iter_val_s == '0);
                    s_d      = iter_val_s[DWIDTH-1];
                    state_d  = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'b0000;
            opa_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            o_q         <= 1'b0;
            s_q         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_MC_MUL_EN
            acc_q       <= '0;
            opb_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            c_q         <= c_d;
            z_q         <= z_d;
            o_q         <= o_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ALU_MC_MUL_EN
            acc_q       <= acc_d;
            opb_q       <= opb_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign o_flag    = o_q;
    assign s_flag    = s_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- table-driven bench for alu_mc (DWIDTH=32) with a scoreboard
// queue: expectations are pushed on acceptance and popped on out_valid.
// Hand-written sequences cover reset state, back-pressure and reset mid-op.
module tb_alu_mc;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op1, op2;
    logic [3:0]    ALUopsel;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          c_flag, z_flag, o_flag, s_flag;

    always #5 clk = ~clk;

    alu_mc #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .ALUopsel  (ALUopsel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .o_flag    (o_flag),
        .s_flag    (s_flag)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic       c;
        logic       o;
        int         lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        c, z, o, s;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic c,
                        input logic o, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.c = c; v.o = o; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation, scramble inputs while it runs, check latency,
    // pop the scoreboard on out_valid, then consume the result.
    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t g;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check1({v.name, "/ready"}, 32'(in_ready), 32'd1);
        ALUopsel = v.op; op1 = v.a; op2 = v.b; in_valid = 1'b1;
        e.res = v.res; e.c = v.c; e.o = v.o; e.z = (v.res == 32'd0); e.s = v.res[31];
        step();
        sb.push_back(e);
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; ALUopsel = 4'($urandom);
        n = 1;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check1({v.name, "/latency"}, 32'(n), 32'(v.lat));
        if (sb.size() > 0) begin
            g = sb.pop_front();
            check1({v.name, "/result"}, result, g.res);
            check1({v.name, "/flags_czos"}, {28'd0, c_flag, z_flag, o_flag, s_flag},
                   {28'd0, g.c, g.z, g.o, g.s});
        end else begin
            check1({v.name, "/scoreboard_nonempty"}, 32'd0, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check1({v.name, "/release_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int   seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; ALUopsel = 4'b0000;

        addv("add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1);
        addv("sub_borrow",4'b0011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 1);
        addv("shl_4",     4'b1101, 32'h80000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 5);
        addv("shr_1",     4'b1100, 32'h00000003, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 2);
        addv("add_carry", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1);
        addv("sub_ovf",   4'b0011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
        addv("sub_zero",  4'b0011, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 1);
        addv("sub_negb",  4'b0011, 32'h00000003, 32'hFFFFFFFF, 32'h00000004, 1'b1, 1'b0, 1);
        addv("and",       4'b1000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1);
        addv("or",        4'b1001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1);
        addv("xor",       4'b1010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1);
        addv("not",       4'b1011, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0, 1);
        addv("pass_2",    4'b0010, 32'hA5A5A5A5, 32'h00000001, 32'hA5A5A5A5, 1'b0, 1'b0, 1);
        addv("pass_4",    4'b0100, 32'h5A5A5A5A, 32'h00000002, 32'h5A5A5A5A, 1'b0, 1'b0, 1);
        addv("pass_6",    4'b0110, 32'h80000000, 32'h00000003, 32'h80000000, 1'b0, 1'b0, 1);
        addv("undef_7",   4'b0111, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0, 1'b0, 1);
        addv("undef_f",   4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1);
        addv("shl_0",     4'b1101, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1);
        addv("shr_31",    4'b1100, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 32);
        addv("shl_31",    4'b1101, 32'h00000003, 32'h0000001F, 32'h80000000, 1'b1, 1'b0, 32);
`ifdef ALU_MC_MUL_EN
        addv("mul",       4'b0101, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0, 1'b0, 33);
        addv("mul_wrap",  4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33);
`else
        addv("mul_off",   4'b0101, 32'h00010003, 32'h00020005, 32'h00000000, 1'b0, 1'b0, 1);
`endif

        // Reset state.
        repeat (3) step();
        check1("rst/result", result, 32'd0);
        check1("rst/flags_ov", {26'd0, c_flag, z_flag, o_flag, s_flag, out_valid, 1'b0}, 32'd0);
        rst_n = 1'b1;
        step();
        check1("rst/in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v);
        end

        // Back-pressure: hold DONE for 10 cycles while offering another op.
        ALUopsel = 4'b0000; op1 = 32'h7FFFFFFF; op2 = 32'h00000001; in_valid = 1'b1;
        step();
        ALUopsel = 4'b0011; op1 = 32'h00000000; op2 = 32'h00000001;
        for (int k = 0; k < 10; k++) begin
            check1("stall/result", result, 32'h80000000);
            check1("stall/czos_rdy_ov", {26'd0, c_flag, z_flag, o_flag, s_flag, in_ready, out_valid},
                   {26'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check1("stall/release", {30'd0, out_valid, in_ready}, 32'd1);
        repeat (3) step();
        check1("stall/no_extra_out", 32'(out_valid), 32'd0);

        // Reset in the middle of a long operation.
`ifdef ALU_MC_MUL_EN
        ALUopsel = 4'b0101; op1 = 32'h00010003; op2 = 32'h00020005;
`else
        ALUopsel = 4'b1100; op1 = 32'h80000000; op2 = 32'h0000001F;
`endif
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check1("abort/busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check1("abort/idle", {30'd0, out_valid, in_ready}, 32'd1);
        check1("abort/result", result, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid) seen++;
        end
        check1("abort/no_stale_out", 32'(seen), 32'd0);

        // Block still works after the abort.
        addv("post_abort", 4'b0000, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1);
        v = vecs[vecs.size() - 1];
        run_op(v);

        check1("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, operand/result width (>= 8, power of two).
REQ-002 The block SHALL have parameter SHW, default $clog2(DWIDTH), shift-amount width (derived, not overridden).
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 The block SHALL have port in_valid  in  1  operation offered.
REQ-006 The block SHALL have port in_ready  out  1  block can accept an operation.
REQ-007 The block SHALL have port op1  in  DWIDTH  first operand.
REQ-008 The block SHALL have port op2  in  DWIDTH  second operand; shift ops use op2[SHW-1:0].
REQ-009 The block SHALL have port ALUopsel  in  4  opcode.
REQ-010 The block SHALL have port out_valid  out  1  result/flags valid.
REQ-011 The block SHALL have port out_ready  in  1  consumer accepts result.
REQ-012 The block SHALL have port result  out  DWIDTH  registered result.
REQ-013 The block SHALL have ports c_flag, z_flag, o_flag, s_flag  out  1 each  registered carry/zero/overflow/sign.

Function
REQ-014 Opcodes SHALL be: 0000 ADD, 0011 SUB, 1000 AND, 1001 OR, 1011 NOT op1, 1010 XOR, 1101 SHL by op2[SHW-1:0], 1100 SHR logical by op2[SHW-1:0], 0101 MUL (low DWIDTH bits, unsigned), 0010/0100/0110 PASS op1; any other code yields result 0.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE; transfer occurs when in_valid && in_ready at a rising edge.
REQ-016 Single-cycle ops (ADD, SUB, logic, PASS, undefined, shift by 0) SHALL go IDLE->DONE, out_valid high the cycle after acceptance.
REQ-017 SHL/SHR by k>0 SHALL iterate one bit per cycle in BUSY, out_valid asserted exactly k+1 cycles after acceptance.
REQ-018 MUL SHALL shift-and-add one op2 bit per cycle, BUSY for DWIDTH cycles, out_valid asserted DWIDTH+1 cycles after acceptance.
REQ-019 In DONE, result and flags SHALL hold stable while out_valid && !out_ready; on out_ready the FSM SHALL return to IDLE next cycle (out_valid low).
REQ-020 Operands and opcode SHALL be captured at acceptance; input changes during BUSY/DONE SHALL have no effect.
REQ-021 c_flag SHALL be: ADD carry-out; SUB borrow (1 iff op1 < op2 unsigned); shifts last bit shifted out (0 when k=0); all others 0.
REQ-022 o_flag SHALL be signed two's-complement overflow for ADD/SUB, 0 for all others.
REQ-023 z_flag SHALL be 1 iff result == 0; s_flag SHALL equal result[DWIDTH-1].
REQ-024 Arithmetic SHALL wrap modulo 2^DWIDTH; MUL upper product bits SHALL be discarded.

Reset
REQ-025 With rst_n low at a rising edge, FSM SHALL enter IDLE and result, all flags, out_valid SHALL be 0; in_ready SHALL be 1 from the first cycle after reset release.
REQ-026 Reset during BUSY or DONE SHALL abort the operation with no output produced.

Configuration
REQ-027 Macro ALU_MC_MUL_EN defined SHALL include the MUL datapath and opcode 0101 per REQ-018.
REQ-028 Without ALU_MC_MUL_EN, opcode 0101 SHALL behave as an undefined opcode (result 0, z_flag 1, one-cycle latency) and no multiplier logic SHALL be synthesised.

Structure
REQ-029 Package alu_mc_pkg SHALL hold the opcode enum (4-bit) and FSM state enum.
REQ-030 Sub-module alu_mc_core SHALL implement the combinational single-cycle ops and ADD/SUB flag generation; alu_mc SHALL own FSM, iteration registers and handshake.

Verification
REQ-031 Reset then ADD 0x7FFFFFFF+0x00000001 -> out_valid at cycle+1, result 0x80000000, o=1, s=1, c=0, z=0.
REQ-032 SUB 0x00000005-0x00000007 -> result 0xFFFFFFFE, c=1, o=0, s=1.
REQ-033 SHL 0x80000001 by 4 -> out_valid 5 cycles after acceptance, result 0x00000010, c=0; SHR 0x00000003 by 1 -> result 0x00000001, c=1.
REQ-034 MUL 0x00010003*0x00020005 (MUL_EN) -> result 0x000B000F after 33 cycles; without macro -> result 0, z=1 at cycle+1.
REQ-035 out_ready held low 10 cycles in DONE -> result/flags stable, in_ready 0, new in_valid ignored until release.
REQ-036 rst_n low mid-MUL -> next cycle IDLE, out_valid 0, in_ready 1, no stale result emitted.
